// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard sequencer
//
// Package pipe_ctrl_pkg
//   state_t    : sequencer states (RUN, MEM_WAIT)
//   stage_en_t : one enable bit per pipeline register plus the PC
//   FWD_*      : ALU operand source encodings
//   REG_X0     : hard-wired zero register, never a hazard or forwarding source
//   fwd_sel()  : operand source select for one source register

package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_en_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [4:0] REG_X0 = 5'd0;

  // The MEM stage holds the younger result, so it wins over WB when both
  // target the same register.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] mem_rd,
    input logic       mem_ruwr,
    input logic [4:0] wb_rd,
    input logic       wb_ruwr
  );
    logic [1:0] sel;
    sel = FWD_REG;
    if (rs != REG_X0) begin
      if (mem_ruwr && (mem_rd == rs)) begin
        sel = FWD_MEM;
      end else if (wb_ruwr && (wb_rd == rs)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - bundle between the datapath and the hazard sequencer
//
// master : datapath side, drives register ids, hazard flags and the data
//          memory handshake; receives stage enables, flushes, forwarding
//          selects, the timeout flag and the performance counters.
// slave  : hazard sequencer side, the mirror image.

interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);

  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic             ex_dmrd;
  logic [4:0]       mem_rd;
  logic [4:0]       wb_rd;
  logic             mem_ruwr;
  logic             wb_ruwr;
  logic             ex_br_taken;
  logic             dm_req;
  logic             dm_ready;

  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] wait_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rs1, ex_rs2, ex_rd, ex_dmrd,
    output mem_rd, wb_rd, mem_ruwr, wb_ruwr,
    output ex_br_taken, dm_req, dm_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, fwd_a, fwd_b,
    input  mem_timeout, stall_cnt, flush_cnt, wait_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rs1, ex_rs2, ex_rd, ex_dmrd,
    input  mem_rd, wb_rd, mem_ruwr, wb_ruwr,
    input  ex_br_taken, dm_req, dm_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, fwd_a, fwd_b,
    output mem_timeout, stall_cnt, flush_cnt, wait_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// rtl/pipeline_hazard_ctrl_forward_unit.sv - combinational ALU operand forwarding select
//
// Ports
//   ex_rs1, ex_rs2   : source registers of the instruction in EX
//   mem_rd, mem_ruwr : MEM-stage destination and write enable
//   wb_rd, wb_ruwr   : WB-stage destination and write enable
//   fwd_a, fwd_b     : operand source, 00 reg file, 01 MEM, 10 WB
// Purely combinational; equally usable for the branch comparator operands.

module forward_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] mem_rd,
  input  logic       mem_ruwr,
  input  logic [4:0] wb_rd,
  input  logic       wb_ruwr,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  assign fwd_a = fwd_sel(ex_rs1, mem_rd, mem_ruwr, wb_rd, wb_ruwr);
  assign fwd_b = fwd_sel(ex_rs2, mem_rd, mem_ruwr, wb_rd, wb_ruwr);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard sequencer for the 5-stage RV32I pipeline
//
// Load-use stalls, operand forwarding, branch squash and data-memory wait
// freeze with a bounded wait and a sticky timeout flag.
//
// Ports
//   clk, rst_n : core clock, asynchronous active-low reset
//   hz (slave) : datapath bundle, see pipeline_hazard_ctrl_if
// Parameters
//   MAX_WAIT   : MEM_WAIT cycles allowed before timeout (2..255)
//   CNT_W      : performance counter width
// Build option
//   HAZARD_PERF_CNT_EN : when defined, stall_cnt/flush_cnt/wait_cnt are live
//                        counters; otherwise they read as zero.

module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state;
  logic [7:0] wait_q;
  logic       branch_pend;
  logic       mem_timeout_q;

  logic       rs1_hit;
  logic       rs2_hit;
  logic       load_use;
  logic       in_wait;
  logic       timeout_now;
  logic       frozen;
  logic       normal;
  logic       br_apply;
  logic       lu_apply;

  stage_en_t  en;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  forward_unit u_fwd (
    .ex_rs1   (hz.ex_rs1),
    .ex_rs2   (hz.ex_rs2),
    .mem_rd   (hz.mem_rd),
    .mem_ruwr (hz.mem_ruwr),
    .wb_rd    (hz.wb_rd),
    .wb_ruwr  (hz.wb_ruwr),
    .fwd_a    (fwd_a_raw),
    .fwd_b    (fwd_b_raw)
  );

  // Cycle classification: frozen (all stages hold), timeout release (only
  // EX/MEM advances so the stuck access retires) or normal flow.
  always_comb begin
    rs1_hit     = hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd);
    rs2_hit     = hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd);
    load_use    = hz.ex_dmrd && (hz.ex_rd != REG_X0) && (rs1_hit || rs2_hit);
    in_wait     = (state == MEM_WAIT);
    timeout_now = in_wait && !hz.dm_ready && (wait_q == WAIT_LAST);
    frozen      = in_wait ? (!hz.dm_ready && !timeout_now)
                          : (hz.dm_req && !hz.dm_ready);
    normal      = !frozen && !timeout_now;
    // A branch resolved while frozen is remembered and applied on release.
    br_apply    = normal && (hz.ex_br_taken || branch_pend);
    // Squashing the branch shadow already removes the dependent instruction.
    lu_apply    = normal && !br_apply && load_use;
  end

  always_comb begin
    en          = '0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!rst_n) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (normal) begin
      en.pc       = !lu_apply;
      en.if_id    = !lu_apply;
      en.id_ex    = 1'b1;
      en.ex_mem   = 1'b1;
      en.mem_wb   = 1'b1;
      if_id_flush = br_apply;
      id_ex_flush = br_apply || lu_apply;
    end else if (timeout_now) begin
      en.ex_mem = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      wait_q        <= 8'd0;
      branch_pend   <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (hz.dm_req && !hz.dm_ready) begin
            state  <= MEM_WAIT;
            wait_q <= 8'd0;
          end
        end
        MEM_WAIT: begin
          wait_q <= wait_q + 8'd1;
          if (hz.dm_ready || timeout_now) begin
            state <= RUN;
          end
          if (timeout_now) begin
            mem_timeout_q <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase

      if (br_apply) begin
        branch_pend <= 1'b0;
      end else if (frozen && hz.ex_br_taken) begin
        branch_pend <= 1'b1;
      end
    end
  end

  assign hz.pc_en       = en.pc;
  assign hz.if_id_en    = en.if_id;
  assign hz.id_ex_en    = en.id_ex;
  assign hz.ex_mem_en   = en.ex_mem;
  assign hz.mem_wb_en   = en.mem_wb;
  assign hz.if_id_flush = if_id_flush;
  assign hz.id_ex_flush = id_ex_flush;
  assign hz.fwd_a       = rst_n ? fwd_a_raw : FWD_REG;
  assign hz.fwd_b       = rst_n ? fwd_b_raw : FWD_REG;
  assign hz.mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic [CNT_W-1:0] wait_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q    <= '0;
      flush_q    <= '0;
      wait_cnt_q <= '0;
    end else begin
      if (lu_apply) stall_q    <= stall_q + 1'b1;
      if (br_apply) flush_q    <= flush_q + 1'b1;
      if (in_wait)  wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  assign hz.stall_cnt = stall_q;
  assign hz.flush_cnt = flush_q;
  assign hz.wait_cnt  = wait_cnt_q;
`else
  assign hz.stall_cnt = {CNT_W{1'b0}};
  assign hz.flush_cnt = {CNT_W{1'b0}};
  assign hz.wait_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl

module tb_pipeline_hazard_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 32;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

  pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: are we waiting on memory, how many wait cycles
  // have elapsed, is a branch remembered, sticky timeout, event totals.
  bit               m_waiting;
  int               m_waited;
  bit               m_pend;
  bit               m_timeout;
  logic [CNT_W-1:0] m_stall;
  logic [CNT_W-1:0] m_flush;
  logic [CNT_W-1:0] m_wait;

  function automatic logic [CNT_W-1:0] cexp(input logic [CNT_W-1:0] v);
    return PERF ? v : '0;
  endfunction

  function automatic logic [6:0] ctl();
    return {hif.pc_en, hif.if_id_en, hif.id_ex_en, hif.ex_mem_en, hif.mem_wb_en,
            hif.if_id_flush, hif.id_ex_flush};
  endfunction

  function automatic logic [11:0] obs();
    return {ctl(), hif.fwd_a, hif.fwd_b, hif.mem_timeout};
  endfunction

  function automatic logic [1:0] fwd_model(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (hif.mem_ruwr && hif.mem_rd == rs) return 2'b01;
    if (hif.wb_ruwr && hif.wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_waiting = 0; m_waited = 0; m_pend = 0; m_timeout = 0;
    m_stall = '0; m_flush = '0; m_wait = '0;
  endtask

  task automatic model_eval(output logic [11:0] v, output bit frz, output bit tmo,
                            output bit br, output bit lu);
    bit         hit;
    logic [4:0] en5;
    logic [1:0] fl;
    logic [1:0] fa;
    logic [1:0] fb;
    hit = hif.ex_dmrd && (hif.ex_rd != 5'd0) &&
          ((hif.id_use_rs1 && hif.id_rs1 == hif.ex_rd) ||
           (hif.id_use_rs2 && hif.id_rs2 == hif.ex_rd));
    tmo = m_waiting && !hif.dm_ready && (m_waited == MAX_WAIT - 1);
    frz = m_waiting ? (!hif.dm_ready && !tmo) : (hif.dm_req && !hif.dm_ready);
    br  = !frz && !tmo && (hif.ex_br_taken || m_pend);
    lu  = !frz && !tmo && !br && hit;
    if (!rst_n)   begin en5 = 5'b00000; fl = 2'b11; end
    else if (frz) begin en5 = 5'b00000; fl = 2'b00; end
    else if (tmo) begin en5 = 5'b00010; fl = 2'b00; end
    else          begin en5 = lu ? 5'b00111 : 5'b11111; fl = {br, br || lu}; end
    fa = rst_n ? fwd_model(hif.ex_rs1) : 2'b00;
    fb = rst_n ? fwd_model(hif.ex_rs2) : 2'b00;
    v  = {en5, fl, fa, fb, m_timeout};
  endtask

  task automatic model_step();
    logic [11:0] v;
    bit frz, tmo, br, lu;
    if (!rst_n) begin
      model_reset();
    end else begin
      model_eval(v, frz, tmo, br, lu);
      if (br) m_pend = 0;
      else if (frz && hif.ex_br_taken) m_pend = 1;
      m_stall = m_stall + CNT_W'(lu);
      m_flush = m_flush + CNT_W'(br);
      m_wait  = m_wait + CNT_W'(m_waiting);
      if (tmo) m_timeout = 1;
      if (m_waiting) begin
        m_waited++;
        if (!frz) m_waiting = 0;
      end else if (frz) begin
        m_waiting = 1;
        m_waited  = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic set_idle();
    hif.id_rs1 = 5'd1; hif.id_rs2 = 5'd2; hif.id_use_rs1 = 0; hif.id_use_rs2 = 0;
    hif.ex_rs1 = 5'd3; hif.ex_rs2 = 5'd4; hif.ex_rd = 5'd0; hif.ex_dmrd = 0;
    hif.mem_rd = 5'd0; hif.wb_rd = 5'd0; hif.mem_ruwr = 0; hif.wb_ruwr = 0;
    hif.ex_br_taken = 0; hif.dm_req = 0; hif.dm_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; set_idle();
    hif.mem_ruwr = 1; hif.mem_rd = 5'd3;
    #2;
    checks++;
    if (ctl() !== 7'b0000011) begin
      failures++; $display("FAIL reset_ctl: got %b expected %b", ctl(), 7'b0000011);
    end
    checks++;
    if ({hif.fwd_a, hif.fwd_b, hif.mem_timeout} !== 5'b00000) begin
      failures++; $display("FAIL reset_fwd_timeout: got %b expected 00000",
                           {hif.fwd_a, hif.fwd_b, hif.mem_timeout});
    end
    checks++;
    if ({hif.stall_cnt, hif.flush_cnt, hif.wait_cnt} !== '0) begin
      failures++; $display("FAIL reset_counters: got %0d %0d %0d expected 0 0 0",
                           hif.stall_cnt, hif.flush_cnt, hif.wait_cnt);
    end
    tick();
    rst_n = 1'b1; set_idle();
    #2;
    checks++;
    if (ctl() !== 7'b1111100) begin
      failures++; $display("FAIL reset_release: got %b expected %b", ctl(), 7'b1111100);
    end
    tick();
  endtask

  task automatic test_load_use();
    set_idle(); hif.ex_dmrd = 1; hif.ex_rd = 5'd5; hif.id_rs1 = 5'd5; hif.id_use_rs1 = 1;
    #2;
    checks++;
    if (ctl() !== 7'b0011101) begin
      failures++; $display("FAIL load_use_stall: got %b expected %b", ctl(), 7'b0011101);
    end
    tick();
    set_idle();
    #2;
    checks++;
    if (ctl() !== 7'b1111100) begin
      failures++; $display("FAIL load_use_after: got %b expected %b", ctl(), 7'b1111100);
    end
    checks++;
    if (hif.stall_cnt !== cexp(1)) begin
      failures++; $display("FAIL load_use_cnt: got %0d expected %0d", hif.stall_cnt, cexp(1));
    end
    tick();
    set_idle(); hif.ex_dmrd = 1; hif.ex_rd = 5'd0; hif.id_rs2 = 5'd0; hif.id_use_rs2 = 1;
    #2;
    checks++;
    if (ctl() !== 7'b1111100) begin
      failures++; $display("FAIL load_use_x0: got %b expected %b", ctl(), 7'b1111100);
    end
    tick();
    set_idle(); hif.ex_dmrd = 1; hif.ex_rd = 5'd6; hif.id_rs2 = 5'd6; hif.id_use_rs2 = 0;
    #2;
    checks++;
    if (ctl() !== 7'b1111100) begin
      failures++; $display("FAIL load_use_unused: got %b expected %b", ctl(), 7'b1111100);
    end
    tick();
  endtask

  task automatic test_forward();
    set_idle(); hif.mem_rd = 5'd7; hif.wb_rd = 5'd7; hif.mem_ruwr = 1; hif.wb_ruwr = 1;
    hif.ex_rs2 = 5'd7;
    #2;
    checks++;
    if (hif.fwd_b !== 2'b01 || hif.fwd_a !== 2'b00) begin
      failures++; $display("FAIL fwd_mem_first: got a=%b b=%b expected a=00 b=01", hif.fwd_a, hif.fwd_b);
    end
    tick();
    hif.mem_ruwr = 0; hif.ex_rs1 = 5'd7;
    #2;
    checks++;
    if (hif.fwd_b !== 2'b10 || hif.fwd_a !== 2'b10) begin
      failures++; $display("FAIL fwd_wb: got a=%b b=%b expected a=10 b=10", hif.fwd_a, hif.fwd_b);
    end
    tick();
    hif.mem_ruwr = 1; hif.mem_rd = 5'd0; hif.wb_rd = 5'd0; hif.ex_rs2 = 5'd0;
    #2;
    checks++;
    if (hif.fwd_b !== 2'b00) begin
      failures++; $display("FAIL fwd_x0: got %b expected 00", hif.fwd_b);
    end
    tick();
  endtask

  task automatic test_branch_vs_load_use();
    set_idle(); hif.ex_dmrd = 1; hif.ex_rd = 5'd9; hif.id_rs1 = 5'd9; hif.id_use_rs1 = 1;
    hif.ex_br_taken = 1;
    #2;
    checks++;
    if (ctl() !== 7'b1111111) begin
      failures++; $display("FAIL branch_priority: got %b expected %b", ctl(), 7'b1111111);
    end
    tick();
    set_idle();
    #2;
    checks++;
    if (hif.stall_cnt !== cexp(1) || hif.flush_cnt !== cexp(1)) begin
      failures++; $display("FAIL branch_counts: got stall=%0d flush=%0d expected %0d %0d",
                           hif.stall_cnt, hif.flush_cnt, cexp(1), cexp(1));
    end
    tick();
  endtask

  task automatic test_mem_wait();
    for (int c = 0; c < 3; c++) begin
      set_idle(); hif.dm_req = 1;
      #2;
      checks++;
      if (ctl() !== 7'b0000000) begin
        failures++; $display("FAIL mem_wait_freeze%0d: got %b expected 0000000", c, ctl());
      end
      tick();
    end
    set_idle(); hif.dm_req = 1; hif.dm_ready = 1;
    #2;
    checks++;
    if (ctl() !== 7'b1111100) begin
      failures++; $display("FAIL mem_wait_release: got %b expected %b", ctl(), 7'b1111100);
    end
    tick();
    set_idle();
    #2;
    checks++;
    if (hif.wait_cnt !== cexp(3) || hif.mem_timeout !== 1'b0 || ctl() !== 7'b1111100) begin
      failures++; $display("FAIL mem_wait_after: got wait=%0d to=%b ctl=%b expected %0d 0 1111100",
                           hif.wait_cnt, hif.mem_timeout, ctl(), cexp(3));
    end
    tick();
  endtask

  task automatic test_branch_during_wait();
    for (int c = 0; c < 3; c++) begin
      set_idle(); hif.dm_req = 1; hif.ex_br_taken = (c == 1);
      #2;
      checks++;
      if (ctl() !== 7'b0000000) begin
        failures++; $display("FAIL br_wait_frozen%0d: got %b expected 0000000", c, ctl());
      end
      tick();
    end
    set_idle(); hif.dm_ready = 1;
    #2;
    checks++;
    if (ctl() !== 7'b1111111) begin
      failures++; $display("FAIL br_wait_release: got %b expected %b", ctl(), 7'b1111111);
    end
    tick();
    set_idle();
    #2;
    checks++;
    if (ctl() !== 7'b1111100 || hif.flush_cnt !== cexp(2)) begin
      failures++; $display("FAIL br_wait_after: got ctl=%b flush=%0d expected 1111100 %0d",
                           ctl(), hif.flush_cnt, cexp(2));
    end
    tick();
  endtask

  task automatic test_timeout();
    for (int c = 0; c < 4; c++) begin
      set_idle(); hif.dm_req = 1;
      #2;
      checks++;
      if (ctl() !== 7'b0000000 || hif.mem_timeout !== 1'b0) begin
        failures++; $display("FAIL timeout_freeze%0d: got %b to=%b expected 0000000 0",
                             c, ctl(), hif.mem_timeout);
      end
      tick();
    end
    set_idle(); hif.dm_req = 1;
    #2;
    checks++;
    if (ctl() !== 7'b0001000) begin
      failures++; $display("FAIL timeout_retire: got %b expected %b", ctl(), 7'b0001000);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      set_idle();
      #2;
      checks++;
      if (hif.mem_timeout !== 1'b1 || ctl() !== 7'b1111100) begin
        failures++; $display("FAIL timeout_sticky%0d: got to=%b ctl=%b expected 1 1111100",
                             c, hif.mem_timeout, ctl());
      end
      tick();
    end
    checks++;
    if (hif.wait_cnt !== cexp(10)) begin
      failures++; $display("FAIL timeout_wait_cnt: got %0d expected %0d", hif.wait_cnt, cexp(10));
    end
  endtask

  task automatic test_reset_mid_wait();
    set_idle(); hif.dm_req = 1; tick();
    set_idle(); hif.ex_br_taken = 1; tick();
    rst_n = 1'b0; set_idle();
    model_reset();
    #2;
    checks++;
    if (hif.mem_timeout !== 1'b0 || ctl() !== 7'b0000011) begin
      failures++; $display("FAIL reset_mid_wait: got to=%b ctl=%b expected 0 0000011",
                           hif.mem_timeout, ctl());
    end
    tick();
    rst_n = 1'b1; set_idle();
    #2;
    checks++;
    if (ctl() !== 7'b1111100 || hif.wait_cnt !== '0) begin
      failures++; $display("FAIL reset_mid_wait_run: got ctl=%b wait=%0d expected 1111100 0",
                           ctl(), hif.wait_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    logic [11:0] v;
    bit frz, tmo, br, lu;
    for (int n = 0; n < 600; n++) begin
      rst_n           = ($urandom_range(0, 79) != 0);
      hif.id_rs1      = 5'($urandom_range(0, 3));
      hif.id_rs2      = 5'($urandom_range(0, 3));
      hif.id_use_rs1  = 1'($urandom);
      hif.id_use_rs2  = 1'($urandom);
      hif.ex_rs1      = 5'($urandom_range(0, 3));
      hif.ex_rs2      = 5'($urandom_range(0, 3));
      hif.ex_rd       = 5'($urandom_range(0, 3));
      hif.ex_dmrd     = 1'($urandom);
      hif.mem_rd      = 5'($urandom_range(0, 3));
      hif.wb_rd       = 5'($urandom_range(0, 3));
      hif.mem_ruwr    = 1'($urandom);
      hif.wb_ruwr     = 1'($urandom);
      hif.ex_br_taken = ($urandom_range(0, 5) == 0);
      hif.dm_req      = ($urandom_range(0, 3) == 0);
      hif.dm_ready    = ($urandom_range(0, 4) == 0);
      if (!rst_n) model_reset();
      #2;
      model_eval(v, frz, tmo, br, lu);
      checks++;
      if (obs() !== v) begin
        failures++; $display("FAIL random_outputs@%0d: got %b expected %b", n, obs(), v);
      end
      checks++;
      if (hif.stall_cnt !== cexp(m_stall) || hif.flush_cnt !== cexp(m_flush) ||
          hif.wait_cnt !== cexp(m_wait)) begin
        failures++; $display("FAIL random_counters@%0d: got %0d %0d %0d expected %0d %0d %0d", n,
                             hif.stall_cnt, hif.flush_cnt, hif.wait_cnt,
                             cexp(m_stall), cexp(m_flush), cexp(m_wait));
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    model_reset();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_forward();
    test_branch_vs_load_use();
    test_mem_wait();
    test_branch_during_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
